// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes, branch condition codes and flag bit positions.
package cpu_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned COND_W  = 3;
    localparam int unsigned FLAG_W  = 3;
    localparam int unsigned STAT_W  = 16;

    localparam logic [OP_W-1:0] OP_B   = 4'b1100;
    localparam logic [OP_W-1:0] OP_BR  = 4'b1101;
    localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

    localparam logic [COND_W-1:0] COND_NEQ = 3'b000;
    localparam logic [COND_W-1:0] COND_EQ  = 3'b001;
    localparam logic [COND_W-1:0] COND_GT  = 3'b010;
    localparam logic [COND_W-1:0] COND_LT  = 3'b011;
    localparam logic [COND_W-1:0] COND_GTE = 3'b100;
    localparam logic [COND_W-1:0] COND_LTE = 3'b101;
    localparam logic [COND_W-1:0] COND_OVF = 3'b110;
    localparam logic [COND_W-1:0] COND_AL  = 3'b111;

    // Flag vector order is {Z,V,N}
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 0;

endpackage

// File: rtl/adder_16bit.sv
// Plain 16-bit modular adder used for branch target generation.
module adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/cond_eval.sv
// Branch condition evaluation against effective {Z,V,N} flags.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [COND_W-1:0] cond,
    input  logic [FLAG_W-1:0] flags,
    output logic              taken
);

    logic z;
    logic v;
    logic n;

    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_NEQ: taken = ~z;
            COND_EQ:  taken = z;
            COND_GT:  taken = ~z & ~n;
            COND_LT:  taken = n;
            COND_GTE: taken = z | (~z & ~n);
            COND_LTE: taken = n | z;
            COND_OVF: taken = v;
            COND_AL:  taken = 1'b1;
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Decode-stage branch resolution: flag register with EX bypass, target, flush, sticky halt.
// Optional branch statistics counters are enabled with `define BRANCH_STATS_EN.
module branch_resolve
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic               stall,
    input  logic [INSTR_W-1:0] instruction,
    input  logic [ADDR_W-1:0]  pc_plus2,
    input  logic [ADDR_W-1:0]  rs_data,
    input  logic [FLAG_W-1:0]  ex_flag_wr,
    input  logic [FLAG_W-1:0]  ex_flags,
    output logic               flush,
    output logic [ADDR_W-1:0]  branch_target,
    output logic               halt,
    output logic [FLAG_W-1:0]  flags_q
`ifdef BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0]  br_count,
    output logic [STAT_W-1:0]  br_taken
`endif
);

    logic [OP_W-1:0]   opcode;
    logic [COND_W-1:0] cond;
    logic [8:0]        imm9;
    logic              is_b;
    logic              is_br;
    logic              is_branch;
    logic              id_live;
    logic              cond_true;
    logic              hlt_dec;
    logic              halt_q;
    logic [FLAG_W-1:0] eff_flags;
    logic [15:0]       b_offset;
    logic [15:0]       b_sum;

    assign opcode    = instruction[15:12];
    assign cond      = instruction[11:9];
    assign imm9      = instruction[8:0];
    assign is_b      = (opcode == OP_B);
    assign is_br     = (opcode == OP_BR);
    assign is_branch = is_b | is_br;
    assign id_live   = id_valid & ~stall;

    // EX-to-ID bypass, per flag bit
    assign eff_flags = (ex_flag_wr & ex_flags) | (~ex_flag_wr & flags_q);

    cond_eval u_cond_eval (
        .cond  (cond),
        .flags (eff_flags),
        .taken (cond_true)
    );

    assign b_offset = {{6{imm9[8]}}, imm9, 1'b0};

    adder_16bit u_target_add (
        .a   (16'(pc_plus2)),
        .b   (b_offset),
        .sum (b_sum)
    );

    always_comb begin
        branch_target = pc_plus2;
        if (is_b) begin
            branch_target = ADDR_W'(b_sum);
        end else if (is_br) begin
            branch_target = rs_data;
        end
    end

    // Gating with rst_n keeps the combinational outputs quiet while in reset
    assign hlt_dec = rst_n & id_live & (opcode == OP_HLT);
    assign halt    = halt_q | hlt_dec;
    assign flush   = rst_n & id_live & ~halt_q & is_branch & cond_true;

    // Flags keep loading through stall and halt so EX can drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= eff_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_q <= 1'b0;
        end else if (hlt_dec) begin
            halt_q <= 1'b1;
        end
    end

`ifdef BRANCH_STATS_EN
    // Saturating counters, frozen once halted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count <= '0;
            br_taken <= '0;
        end else if (!halt_q) begin
            if (id_live && is_branch && (br_count != '1)) begin
                br_count <= br_count + STAT_W'(1);
            end
            if (flush && (br_taken != '1)) begin
                br_taken <= br_taken + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed vector table plus halt/reset/stats sequences.
module tb_branch_resolve;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        stall;
    logic [15:0] instruction;
    logic [15:0] pc_plus2;
    logic [15:0] rs_data;
    logic [2:0]  ex_flag_wr;
    logic [2:0]  ex_flags;
    logic        flush;
    logic [15:0] branch_target;
    logic        halt;
    logic [2:0]  flags_q;
`ifdef BRANCH_STATS_EN
    logic [15:0] br_count;
    logic [15:0] br_taken;
`endif

    int checks;
    int failures;

    branch_resolve #(.ADDR_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .stall         (stall),
        .instruction   (instruction),
        .pc_plus2      (pc_plus2),
        .rs_data       (rs_data),
        .ex_flag_wr    (ex_flag_wr),
        .ex_flags      (ex_flags),
        .flush         (flush),
        .branch_target (branch_target),
        .halt          (halt),
        .flags_q       (flags_q)
`ifdef BRANCH_STATS_EN
        ,
        .br_count      (br_count),
        .br_taken      (br_taken)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        st;
        logic [15:0] ins;
        logic [15:0] pc;
        logic [15:0] rs;
        logic [2:0]  wr;
        logic [2:0]  fl;
        logic        e_flush;
        logic [15:0] e_tgt;
        logic        e_halt;
        logic [2:0]  e_flags;
    } vec_t;

    vec_t vt[16];

    function automatic logic [15:0] mk_b(input logic [2:0] c, input logic [8:0] imm);
        return {4'b1100, c, imm};
    endfunction

    function automatic logic [15:0] mk_br(input logic [2:0] c);
        return {4'b1101, c, 1'b0, 4'h3, 4'h0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic st, input logic [15:0] ins,
                         input logic [15:0] pc, input logic [15:0] rs,
                         input logic [2:0] wr, input logic [2:0] fl);
        id_valid    = v;
        stall       = st;
        instruction = ins;
        pc_plus2    = pc;
        rs_data     = rs;
        ex_flag_wr  = wr;
        ex_flags    = fl;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'b000, 3'b000);

        //            v     st    ins                    pc        rs        wr      fl      flush tgt       halt  flags
        vt[0]  = '{1'b0, 1'b0, 16'h0000,             16'h1234, 16'h0000, 3'b000, 3'b000, 1'b0, 16'h1234, 1'b0, 3'b000};
        vt[1]  = '{1'b1, 1'b0, mk_b(3'b001, 9'h1FE), 16'h0010, 16'h0000, 3'b100, 3'b100, 1'b1, 16'h000C, 1'b0, 3'b000};
        vt[2]  = '{1'b0, 1'b0, 16'h0000,             16'h0020, 16'h0000, 3'b000, 3'b000, 1'b0, 16'h0020, 1'b0, 3'b100};
        vt[3]  = '{1'b1, 1'b0, mk_b(3'b000, 9'h004), 16'h0100, 16'h0000, 3'b000, 3'b000, 1'b0, 16'h0108, 1'b0, 3'b100};
        vt[4]  = '{1'b0, 1'b0, 16'h0000,             16'h0000, 16'h0000, 3'b001, 3'b001, 1'b0, 16'h0000, 1'b0, 3'b100};
        vt[5]  = '{1'b1, 1'b0, mk_br(3'b011),        16'h0200, 16'hABCD, 3'b000, 3'b000, 1'b1, 16'hABCD, 1'b0, 3'b101};
        vt[6]  = '{1'b1, 1'b1, mk_br(3'b011),        16'h0200, 16'hABCD, 3'b000, 3'b000, 1'b0, 16'hABCD, 1'b0, 3'b101};
        vt[7]  = '{1'b1, 1'b0, mk_b(3'b111, 9'h0FF), 16'hFF00, 16'h0000, 3'b000, 3'b000, 1'b1, 16'h00FE, 1'b0, 3'b101};
        vt[8]  = '{1'b1, 1'b0, mk_b(3'b010, 9'h002), 16'h0300, 16'h0000, 3'b000, 3'b000, 1'b0, 16'h0304, 1'b0, 3'b101};
        vt[9]  = '{1'b1, 1'b0, mk_b(3'b100, 9'h002), 16'h0300, 16'h0000, 3'b000, 3'b000, 1'b1, 16'h0304, 1'b0, 3'b101};
        vt[10] = '{1'b1, 1'b0, mk_b(3'b110, 9'h1FF), 16'h0400, 16'h0000, 3'b111, 3'b010, 1'b1, 16'h03FE, 1'b0, 3'b101};
        vt[11] = '{1'b1, 1'b0, mk_b(3'b101, 9'h000), 16'h0500, 16'h0000, 3'b000, 3'b000, 1'b0, 16'h0500, 1'b0, 3'b010};
        vt[12] = '{1'b1, 1'b0, mk_b(3'b010, 9'h000), 16'h0600, 16'h0000, 3'b000, 3'b000, 1'b1, 16'h0600, 1'b0, 3'b010};
        vt[13] = '{1'b1, 1'b0, mk_br(3'b101),        16'h0000, 16'h1357, 3'b001, 3'b001, 1'b1, 16'h1357, 1'b0, 3'b010};
        vt[14] = '{1'b0, 1'b0, 16'h0000,             16'h0000, 16'h0000, 3'b000, 3'b000, 1'b0, 16'h0000, 1'b0, 3'b011};
        vt[15] = '{1'b0, 1'b0, mk_b(3'b000, 9'h001), 16'h0700, 16'h0000, 3'b000, 3'b000, 1'b0, 16'h0702, 1'b0, 3'b011};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_flags", 32'(flags_q), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vt[i].v, vt[i].st, vt[i].ins, vt[i].pc, vt[i].rs, vt[i].wr, vt[i].fl);
            #2;
            chk($sformatf("v%0d_flush", i), 32'(flush), 32'(vt[i].e_flush));
            chk($sformatf("v%0d_target", i), 32'(branch_target), 32'(vt[i].e_tgt));
            chk($sformatf("v%0d_halt", i), 32'(halt), 32'(vt[i].e_halt));
            chk($sformatf("v%0d_flags", i), 32'(flags_q), 32'(vt[i].e_flags));
        end

`ifdef BRANCH_STATS_EN
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'b000, 3'b000);
        #2;
        chk("tbl_br_count", 32'(br_count), 32'd10);
        chk("tbl_br_taken", 32'(br_taken), 32'd7);
`endif

        // Stalled HLT must not halt
        @(negedge clk);
        drive(1'b1, 1'b1, 16'hF000, 16'h0000, 16'h0000, 3'b000, 3'b000);
        #2;
        chk("hlt_stalled", 32'(halt), 32'd0);

        // HLT: immediate halt, sticky, blocks flush, flags still load
        @(negedge clk);
        drive(1'b1, 1'b0, 16'hF000, 16'h0000, 16'h0000, 3'b000, 3'b000);
        #2;
        chk("hlt_same_cycle", 32'(halt), 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'b111, 3'b111);
        #2;
        chk("hlt_sticky", 32'(halt), 32'd1);
        @(negedge clk);
        drive(1'b1, 1'b0, mk_b(3'b111, 9'h004), 16'h0800, 16'h0000, 3'b000, 3'b000);
        #2;
        chk("hlt_no_flush", 32'(flush), 32'd0);
        chk("hlt_flag_load", 32'(flags_q), 32'd7);
        chk("hlt_still", 32'(halt), 32'd1);
`ifdef BRANCH_STATS_EN
        @(negedge clk);
        #2;
        chk("hlt_cnt_frozen", 32'(br_count), 32'd10);
`endif

        // Asynchronous reset mid-cycle with a taken branch still in ID
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_halt", 32'(halt), 32'd0);
        chk("arst_flush", 32'(flush), 32'd0);
        chk("arst_flags", 32'(flags_q), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("post_rst_flush", 32'(flush), 32'd1);
        chk("post_rst_target", 32'(branch_target), 32'h0808);

`ifdef BRANCH_STATS_EN
        // Three branches, two taken (flags are 000 here)
        @(negedge clk);
        drive(1'b1, 1'b0, mk_b(3'b000, 9'h000), 16'h0000, 16'h0000, 3'b000, 3'b000);
        @(negedge clk);
        drive(1'b1, 1'b0, mk_b(3'b001, 9'h000), 16'h0000, 16'h0000, 3'b000, 3'b000);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'b000, 3'b000);
        #2;
        chk("st_count3", 32'(br_count), 32'd3);
        chk("st_taken2", 32'(br_taken), 32'd2);
        force dut.br_count = 16'hFFFF;
        #1;
        release dut.br_count;
        @(negedge clk);
        drive(1'b1, 1'b0, mk_b(3'b111, 9'h000), 16'h0000, 16'h0000, 3'b000, 3'b000);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'b000, 3'b000);
        #2;
        chk("st_saturate", 32'(br_count), 32'hFFFF);
        chk("st_taken3", 32'(br_taken), 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Decode-stage branch resolution unit for the 16-bit pipelined CPU. It sits between the IF/ID pipeline register and the fetch stage. It holds the architectural flag register (Z, V, N), evaluates B/BR conditions against those flags with same-cycle EX bypass, and computes the branch target. It drives the `flush`, `branch_target` and `halt` inputs of fetch, and owns the sticky halt latch and optional branch statistics.

## Interface
Parameters:
- `ADDR_W`, 16: PC/target width.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `id_valid`  in  1  IF/ID holds a real instruction (0 = bubble).
- `stall`  in  1  hazard unit is holding ID this cycle.
- `instruction`  in  16  instruction in ID.
- `pc_plus2`  in  16  PC+2 of the ID instruction.
- `rs_data`  in  16  register-file read of rs, used as the BR target.
- `ex_flag_wr`  in  3  per-flag write enables from EX, bit order {Z,V,N}.
- `ex_flags`  in  3  flag values produced in EX, order {Z,V,N}.
- `flush`  out  1  branch taken; redirect fetch and squash IF/ID.
- `branch_target`  out  16  redirect address.
- `halt`  out  1  freeze the PC.
- `flags_q`  out  3  registered architectural flags {Z,V,N}.

## Operation
- Opcode is `instruction[15:12]`:
  - B = 4'b1100: cond `[11:9]`, imm9 `[8:0]`.
  - BR = 4'b1101: cond `[11:9]`, rs `[7:4]`.
  - HLT = 4'b1111.
- Effective flags, evaluated per bit: `ex_flags[i]` if `ex_flag_wr[i]`, otherwise `flags_q[i]`. This is the EX-to-ID bypass.
- Condition codes:
  - 000 NEQ: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GTE: Z=1 | (Z=0 & N=0)
  - 101 LTE: N=1 | Z=1
  - 110 OVF: V=1
  - 111 always
- Target:
  - B: `pc_plus2 + (sext(imm9) << 1)`, computed modulo 2^16. Wrap-around is silent.
  - BR: `rs_data`.
  - Otherwise `branch_target` = `pc_plus2`. The value is don't-care, but it must be deterministic.
- `flush` = `id_valid & ~stall & ~halt_q & is_branch & cond_true`.
- Halt:
  - `hlt_dec` = `id_valid & ~stall & opcode==HLT`.
  - `halt` = `halt_q | hlt_dec`.
  - `halt_q` sets on `hlt_dec` and clears only on reset.
- Flag register: each bit loads `ex_flags[i]` when `ex_flag_wr[i]`. Writes continue even during stall and halt, because EX instructions drain.
- Simultaneous HLT decode and branch decode cannot occur (single instruction per stage). If `halt_q` is set, `flush` is forced to 0.

## Timing
- Reset values: `flags_q` = 3'b000, `halt_q` = 0, `flush` = 0, `halt` = 0. Counters reset to 0.
- `flush`, `branch_target` and `halt` are combinational from ID inputs and bypass. They take effect at the next posedge in fetch, giving a 1-cycle branch penalty (one squashed fetch).
- `flags_q` updates at the posedge following `ex_flag_wr`. The bypass makes the new value visible to a branch in ID in the same cycle.
- A stalled branch produces no flush. It resolves on the first non-stalled cycle, using flags as they are then.
- Reset asserted mid-operation clears all state immediately and asynchronously. Outputs are at reset values while `rst_n`=0.

## Configuration
- `BRANCH_STATS_EN` defined adds:
  - outputs `br_count[15:0]` and `br_taken[15:0]`;
  - `br_count` increments on every non-stalled valid B/BR in ID;
  - `br_taken` increments on every `flush`;
  - both saturate at 16'hFFFF and freeze while `halt_q`.
- Without the macro, the ports and counters are absent and behaviour is otherwise identical.

## Structure
- Shared package `cpu_pkg`: opcode constants (OP_B, OP_BR, OP_HLT), condition-code constants, flag bit indices (FLAG_Z=2, FLAG_V=1, FLAG_N=0).
- One sub-module, `cond_eval`: combinational, taking 3-bit cond and 3-bit effective flags and returning `taken`.
- The adder reuses the existing `adder_16bit`.

## Test plan
- Reset, then idle with `id_valid`=0: `flags_q`=000, `flush`=0, `halt`=0.
- `ex_flag_wr`=3'b100, `ex_flags`=3'b100 while ID holds B EQ with imm9=9'h1FE, `pc_plus2`=16'h0010: `flush`=1, `branch_target`=16'h000C, and `flags_q`=100 next cycle.
- BR LT with `rs_data`=16'hABCD and `flags_q` N=1, then the same BR with `stall`=1: first case gives `flush`=1 and target ABCD; the stalled case gives `flush`=0.
- B always, imm9=9'h0FF, `pc_plus2`=16'hFF00: `branch_target`=16'h00FE (wrap).
- HLT in ID: `halt`=1 the same cycle and stays 1. A following taken branch gives `flush`=0. Asserting `rst_n`=0 clears `halt`.
- With `BRANCH_STATS_EN`: 3 branches with 2 taken give `br_count`=3 and `br_taken`=2. After preloading `br_count` to FFFF by force, a further branch leaves it at FFFF.
